// File: rtl/table_fsm.sv
// table_fsm: run-time programmable, table-driven Moore FSM.
//
// The next-state function lives in ns_tab (2**(SW+IW) entries, indexed {state,in})
// and the Moore output function in out_tab (2**SW entries, indexed by state). Both
// tables are plain registers written through the cfg_* port.
//
// Optional feature: define TABLE_FSM_STALL_DET_EN to add a sticky self-loop (stall)
// detector; without it stall_o is tied low and STALL_LIM has no effect.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active high; dominates every other input
//   run_i        advance every cycle while high
//   step_i       single-cycle advance pulse
//   in_i         FSM input, sampled on advancing edges
//   cfg_we_i     table write strobe
//   cfg_sel_i    0 = next-state table, 1 = output table
//   cfg_addr_i   table index {state,in}; output table uses the low SW bits
//   cfg_wdata_i  write data; low SW (next-state) or OW (output) bits are stored
//   state_o      current state
//   out_o        Moore output out_tab[state]
//   match_o      state == MATCH_STATE
//   stall_o      sticky self-loop detect
module table_fsm #(
    parameter int SW          = 3,
    parameter int IW          = 1,
    parameter int OW          = 1,
    parameter int RESET_STATE = 0,
    parameter int MATCH_STATE = 1,
    parameter int STALL_LIM   = 15,
    localparam int CW         = (SW > OW) ? SW : OW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             step_i,
    input  logic [IW-1:0]    in_i,
    input  logic             cfg_we_i,
    input  logic             cfg_sel_i,
    input  logic [SW+IW-1:0] cfg_addr_i,
    input  logic [CW-1:0]    cfg_wdata_i,
    output logic [SW-1:0]    state_o,
    output logic [OW-1:0]    out_o,
    output logic             match_o,
    output logic             stall_o
);
    localparam int NS = 2 ** (SW + IW);
    localparam int NO = 2 ** SW;
    localparam logic [SW-1:0] RST_S = SW'(RESET_STATE);
    localparam logic [SW-1:0] MATCH_S = SW'(MATCH_STATE);

    logic [SW-1:0] ns_tab_q [NS];
    logic [OW-1:0] out_tab_q [NO];
    logic [SW-1:0] state_q, state_d, ns_lookup;
    logic          adv;

    assign adv       = run_i | step_i;
    assign ns_lookup = ns_tab_q[{state_q, in_i}];
    assign state_d   = adv ? ns_lookup : state_q;

    // Non-blocking table writes give read-before-write: a transition in the same
    // cycle as a write to its entry uses the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_S;
            for (int i = 0; i < NS; i++) ns_tab_q[i] <= RST_S;
            for (int i = 0; i < NO; i++) out_tab_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_we_i && cfg_sel_i) out_tab_q[cfg_addr_i[SW-1:0]] <= cfg_wdata_i[OW-1:0];
            if (cfg_we_i && !cfg_sel_i) ns_tab_q[cfg_addr_i] <= cfg_wdata_i[SW-1:0];
        end
    end

    assign state_o = state_q;
    assign out_o   = out_tab_q[state_q];
    assign match_o = state_q == MATCH_S;

`ifdef TABLE_FSM_STALL_DET_EN
    localparam int CNTW = (STALL_LIM > 0) ? $clog2(STALL_LIM + 1) : 1;
    localparam logic [CNTW-1:0] LIM = CNTW'(STALL_LIM);

    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            stall_q, stall_d, self_loop, sat;

    assign self_loop = adv && (ns_lookup == state_q);
    assign sat       = cnt_q == LIM;
    assign cnt_inc   = sat ? cnt_q : cnt_q + 1'b1;

    // Any config write restarts detection, since the tables may no longer loop.
    always_comb begin
        cnt_d   = cfg_we_i ? '0 : !adv ? cnt_q : self_loop ? cnt_inc : '0;
        stall_d = cfg_we_i ? 1'b0 : stall_q | (self_loop && cnt_inc == LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_o = stall_q;
`else
    assign stall_o = 1'b0;
`endif
endmodule

// File: tb/tb_table_fsm.sv
// tb_table_fsm: randomized and directed checks of table_fsm against a behavioural model.
module tb_table_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0, step = 1'b0, in = 1'b0, we = 1'b0, sel = 1'b0;
    logic [3:0] addr = '0;
    logic [2:0] wdata = '0;
    logic [2:0] state;
    logic       out, match, stall;

    int checks = 0;
    int failures = 0;

    int ns_m [16];
    int out_m [8];
    int st_m = 0;
    int cnt_m = 0;
    bit stall_m = 0;

    always #5 clk = ~clk;

    table_fsm dut (
        .clk(clk), .rst(rst), .run_i(run), .step_i(step), .in_i(in),
        .cfg_we_i(we), .cfg_sel_i(sel), .cfg_addr_i(addr), .cfg_wdata_i(wdata),
        .state_o(state), .out_o(out), .match_o(match), .stall_o(stall)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one rising edge, using the values driven before it.
    task automatic model_edge();
        int nxt;
        if (rst) begin
            st_m = 0; cnt_m = 0; stall_m = 0;
            foreach (ns_m[i]) ns_m[i] = 0;
            foreach (out_m[i]) out_m[i] = 0;
            return;
        end
        nxt = ns_m[st_m * 2 + int'(in)];
`ifdef TABLE_FSM_STALL_DET_EN
        if (we) begin
            cnt_m = 0; stall_m = 0;
        end else if (run || step) begin
            if (nxt == st_m) begin
                cnt_m = (cnt_m < 15) ? cnt_m + 1 : 15;
                if (cnt_m == 15) stall_m = 1;
            end else cnt_m = 0;
        end
`endif
        if (we && sel) out_m[addr % 8] = int'(wdata[0]);
        if (we && !sel) ns_m[addr] = int'(wdata);
        if (run || step) st_m = nxt;
    endtask

    task automatic tick(input logic r, input logic ru, input logic sp, input logic i,
                        input logic w, input logic s, input logic [3:0] a, input logic [2:0] d);
        @(negedge clk);
        rst = r; run = ru; step = sp; in = i; we = w; sel = s; addr = a; wdata = d;
        @(posedge clk);
        model_edge();
        #1;
        chk("state", int'(state), st_m);
        chk("out", int'(out), out_m[st_m]);
        chk("match", int'(match), int'(st_m == 1));
        chk("stall", int'(stall), int'(stall_m));
    endtask

    initial begin
        foreach (ns_m[i]) ns_m[i] = 0;
        foreach (out_m[i]) out_m[i] = 0;
        // 1: reset defaults, then free run stays in state 0
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_state", int'(state), 0);
        chk("reset_out", int'(out), 0);
        for (int c = 0; c < 10; c++) tick(0, 1, 0, c[0], 0, 0, 0, 0);
        chk("idle_run_state", int'(state), 0);
        // 2: ring 0->2->0 with out_tab[2]=1 (upper wdata bits must be ignored)
        tick(0, 0, 0, 0, 1, 0, 4'd0, 3'd2);
        tick(0, 0, 0, 0, 1, 0, 4'd4, 3'd0);
        tick(0, 0, 0, 0, 1, 1, 4'b1010, 3'b111);
        for (int c = 0; c < 8; c++) tick(0, 1, 0, 0, 0, 0, 0, 0);
        // 3: step pulses, then run and step together advance once
        for (int c = 0; c < 10; c++) tick(0, 0, (c == 3 || c == 7), 0, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0, 0, 0, 0);
        // 4: write the entry being used in the same cycle
        for (int c = 0; c < 4 && st_m != 2; c++) tick(0, 1, 0, 0, 0, 0, 0, 0);
        chk("at_state2", int'(state), 2);
        tick(0, 1, 0, 0, 1, 0, 4'd4, 3'd5);
        chk("rbw_old_entry", int'(state), 0);
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        chk("rbw_new_entry", int'(state), 5);
        // 5: reset with a simultaneous write drops the write
        tick(1, 1, 0, 0, 1, 0, 4'd0, 3'd7);
        chk("mid_reset_state", int'(state), 0);
        for (int c = 0; c < 3; c++) tick(0, 1, 0, 0, 0, 0, 0, 0);
        chk("write_dropped", int'(state), 0);
        // 6: self-loop on state 3
        tick(0, 0, 0, 0, 1, 0, 4'd6, 3'd3);
        tick(0, 0, 0, 0, 1, 0, 4'd7, 3'd3);
        tick(0, 0, 0, 0, 1, 0, 4'd0, 3'd3);
        for (int c = 0; c < 20; c++) tick(0, 1, 0, 1'($urandom_range(1)), 0, 0, 0, 0);
`ifdef TABLE_FSM_STALL_DET_EN
        chk("stall_set", int'(stall), 1);
`else
        chk("stall_off", int'(stall), 0);
`endif
        tick(0, 1, 0, 0, 1, 1, 4'd5, 3'd1);
        chk("stall_cleared", int'(stall), 0);
        // random traffic
        for (int c = 0; c < 400; c++)
            tick($urandom_range(60) == 0, $urandom_range(1) == 0, $urandom_range(3) == 0,
                 1'($urandom_range(1)), $urandom_range(5) == 0, 1'($urandom_range(1)),
                 4'($urandom_range(15)), 3'($urandom_range(7)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
